// File: rtl/write_back_controller.sv
// write_back_controller: write-back sequencing with load extraction, miss stall and miss watchdog
module write_back_controller #(
  parameter int MISS_TIMEOUT  = 255,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic        reg_write_in,
  input  logic        mem_read_in,
  input  logic [2:0]  load_type_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [31:0] alu_out_in,
  input  logic        data_cache_hit_in,
  input  logic [31:0] data_cache_out_data,
  input  logic        flush_in,
  output logic        write_back_mux_select_out,
  output logic        rf_write_en_out,
  output logic [4:0]  rf_write_addr_out,
  output logic [31:0] rf_write_data_out,
  output logic        stall_out,
  output logic        timeout_error_out
);
  localparam logic IDLE = 1'b0;
  localparam logic WAIT = 1'b1;
  logic                     state;
  logic [TIMEOUT_WIDTH-1:0] cnt;
  logic [4:0]               h_rd;
  logic [2:0]               h_type;
  logic [1:0]               h_off;
  logic                     h_rw;
  logic                     idle, accept, commit, c_rw, c_sel, timeout;
  logic [4:0]               c_rd;
  logic [31:0]              c_data;
  function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] t, input logic [1:0] o);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{o, 3'b000} +: 8];
    h = o[1] ? w[31:16] : w[15:0];
    return t == 3'b000 ? {{24{b[7]}}, b} :
           t == 3'b100 ? {24'b0, b} :
           t == 3'b001 ? {{16{h[15]}}, h} :
           t == 3'b101 ? {16'b0, h} : w;
  endfunction
  assign idle      = state == IDLE;
  assign ready_out = idle;
  assign stall_out = ~idle;
  assign accept    = valid_in & idle & ~flush_in;
  assign timeout   = cnt == TIMEOUT_WIDTH'(MISS_TIMEOUT - 1);
  // Select the instruction that retires this cycle: a fresh one from IDLE or the held load in WAIT
  always_comb begin
    commit = idle ? accept & (~mem_read_in | data_cache_hit_in) : ~flush_in & data_cache_hit_in;
    c_sel  = idle ? mem_read_in : 1'b1;
    c_rd   = idle ? rd_addr_in : h_rd;
    c_rw   = idle ? reg_write_in : h_rw;
    c_data = (idle & ~mem_read_in) ? alu_out_in :
             ext(data_cache_out_data, idle ? load_type_in : h_type, idle ? alu_out_in[1:0] : h_off);
  end
  // State, held miss context, watchdog and registered write-back outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                     <= IDLE;
      cnt                       <= '0;
      h_rd                      <= '0;
      h_type                    <= '0;
      h_off                     <= '0;
      h_rw                      <= 1'b0;
      write_back_mux_select_out <= 1'b0;
      rf_write_en_out           <= 1'b0;
      rf_write_addr_out         <= '0;
      rf_write_data_out         <= '0;
      timeout_error_out         <= 1'b0;
    end else begin
      rf_write_en_out <= commit & c_rw & (c_rd != 5'd0);
      if (commit) begin
        write_back_mux_select_out <= c_sel;
        rf_write_addr_out         <= c_rd;
        rf_write_data_out         <= c_data;
      end
      if (idle) begin
        if (accept & mem_read_in & ~data_cache_hit_in) begin
          state  <= WAIT;
          cnt    <= '0;
          h_rd   <= rd_addr_in;
          h_type <= load_type_in;
          h_off  <= alu_out_in[1:0];
          h_rw   <= reg_write_in;
        end
      end else if (flush_in | data_cache_hit_in) begin
        state <= IDLE;
      end else if (timeout) begin
        state             <= IDLE;
        timeout_error_out <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/write_back_controller.md
# write_back_controller

Sequencing controller for the write-back stage. Accepts retiring instructions from the MEM/WB boundary and drives the write-back mux select (ALU result vs data-cache data). Stalls the pipeline on data-cache misses and extracts/extends load data. Issues exactly one register-file write per committed instruction, with a watchdog on outstanding misses.

## Interface
Parameters:
- MISS_TIMEOUT, 255: maximum cycles in WAIT before the watchdog fires (1..65535).
- TIMEOUT_WIDTH, 16: width of the miss-wait counter.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- VALID_IN  input  1  instruction valid at MEM/WB boundary.
- READY_OUT  output  1  controller can accept an instruction this cycle.
- REG_WRITE_IN  input  1  instruction writes rd.
- MEM_READ_IN  input  1  instruction is a load.
- LOAD_TYPE_IN  input  3  RISC-V load funct3.
- RD_ADDR_IN  input  5  destination register.
- ALU_OUT_IN  input  32  ALU result; load address for loads.
- DATA_CACHE_HIT_IN  input  1  DATA_CACHE_OUT_DATA valid this cycle.
- DATA_CACHE_OUT_DATA  input  32  aligned word from data cache.
- FLUSH_IN  input  1  discard any held instruction.
- WRITE_BACK_MUX_SELECT_OUT  output  1  0 = ALU result, 1 = load data.
- RF_WRITE_EN_OUT  output  1  register-file write strobe (one cycle).
- RF_WRITE_ADDR_OUT  output  5  register-file write address.
- RF_WRITE_DATA_OUT  output  32  register-file write data.
- STALL_OUT  output  1  stall request to upstream stages.
- TIMEOUT_ERROR_OUT  output  1  sticky watchdog flag.

## Operation
- States: IDLE, WAIT. Reset enters IDLE.
- Accept occurs when VALID_IN & READY_OUT. READY_OUT = (state == IDLE). STALL_OUT = (state == WAIT).
- IDLE, accepted non-load: commit next cycle with ALU_OUT_IN data and mux select 0.
- IDLE, accepted load with DATA_CACHE_HIT_IN=1 in the same cycle: commit next cycle with extracted load data and mux select 1.
- IDLE, accepted load with hit=0: capture rd, type, address[1:0] and REG_WRITE_IN, then go to WAIT and clear the counter.
- WAIT, hit=1: commit next cycle with extracted data and go to IDLE.
- WAIT, hit=0: counter increments. When counter reaches MISS_TIMEOUT-1 with no hit: set TIMEOUT_ERROR_OUT, drop the instruction (no RF write), go to IDLE.
- FLUSH_IN in WAIT: drop the instruction, go to IDLE. Flush wins over a simultaneous hit and over the timeout.
- FLUSH_IN in IDLE blocks the accept that cycle.
- Commit: RF_WRITE_EN_OUT=1 only if REG_WRITE & rd != 0. Writes to x0 are suppressed, but the instruction still retires.
- Load extraction uses offset = address[1:0]:
  - LB (000): sign-extend byte[offset].
  - LBU (100): zero-extend byte[offset].
  - LH (001): sign-extend half[offset[1]].
  - LHU (101): zero-extend half[offset[1]].
  - LW (010) and all other codes: full word.
  - offset[0] is ignored for halfwords.
- TIMEOUT_ERROR_OUT clears only on reset.

## Timing
- Reset values: READY_OUT=1, STALL_OUT=0, RF_WRITE_EN_OUT=0, RF_WRITE_ADDR_OUT=0, RF_WRITE_DATA_OUT=0, WRITE_BACK_MUX_SELECT_OUT=0, TIMEOUT_ERROR_OUT=0, counter=0.
- All outputs except READY_OUT/STALL_OUT are registered. READY_OUT/STALL_OUT decode the state register, with no combinational path from inputs.
- Latency:
  - Non-load or hitting load: RF write one cycle after accept.
  - Missing load: RF write one cycle after the hit cycle.
- RF_WRITE_EN_OUT is a single-cycle pulse per commit. Back-to-back hits/non-loads give one write per cycle.
- WRITE_BACK_MUX_SELECT_OUT and RF_WRITE_ADDR_OUT hold their last commit value between commits.
- Asserting RST_N low mid-WAIT clears everything immediately; the held instruction is lost.
- Timeout fires on the cycle the counter equals MISS_TIMEOUT-1. The flag and the return to IDLE are visible the next cycle.

## Test plan
- Non-load: accept ADD rd=5, ALU_OUT_IN=0x0000_1234 -> next cycle RF_WRITE_EN_OUT=1, addr=5, data=0x0000_1234, mux select=0; five consecutive ADDs -> five consecutive writes.
- Load hit/extraction: DATA_CACHE_OUT_DATA=0x80FF_7F01; LB addr[1:0]=3 -> 0xFFFF_FF80; LBU addr[1:0]=3 -> 0x0000_0080; LH addr[1:0]=2 -> 0xFFFF_80FF; LHU addr[1:0]=0 -> 0x0000_7F01; LW -> 0x80FF_7F01; mux select=1 each time.
- Miss: load rd=7, hit held low 10 cycles -> STALL_OUT=1, READY_OUT=0 for those cycles, no RF write; hit with 0xDEAD_BEEF (LW) -> write rd=7 data 0xDEAD_BEEF next cycle, READY_OUT=1.
- x0/no-write: ADD rd=0 and load rd=0 -> RF_WRITE_EN_OUT stays 0; REG_WRITE_IN=0 instruction -> no write, accepted in one cycle.
- Flush/timeout: MISS_TIMEOUT=8, miss with no hit -> TIMEOUT_ERROR_OUT=1 after 8 WAIT cycles, no write; second miss with FLUSH_IN and hit in the same cycle -> no write, IDLE next cycle.
- Reset mid-WAIT: drop RST_N during a miss -> all outputs at reset values asynchronously; after release a new ADD commits normally.
